// File: rtl/iter_shifter.sv
// Iterative shift/rotate unit: one bit position per clock, valid/ready on
// both the request and the result side. Same 3-bit opsel encoding as the
// single-cycle barrel shifter.
module iter_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_opsel,
    input  logic [4:0]       in_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic [2:0]       op;
    logic [4:0]       count;

    // One-bit step of the working register for the latched operation.
    always_comb begin
        work_step = work;
        if (op[2:1] == 2'b11) begin
            work_step = {work[WIDTH-1], work[WIDTH-1:1]};
        end else begin
            case (op[1:0])
                2'b00:   work_step = {work[WIDTH-2:0], 1'b0};
                2'b01:   work_step = {1'b0, work[WIDTH-1:1]};
                2'b10:   work_step = {work[WIDTH-2:0], work[WIDTH-1]};
                default: work_step = {work[0], work[WIDTH-1:1]};
            endcase
        end
    end

    // Control FSM plus working register and remaining-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            op    <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        op    <= in_opsel;
                        count <= in_amount;
                        state <= (in_amount == 5'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= work_step;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: expected results are queued when a
// request is accepted and compared when the unit presents its result.
module tb_iter_shifter;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_SRA2 = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_opsel;
    logic [4:0]       in_amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    iter_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_opsel  (in_opsel),
        .in_amount (in_amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of the single-cycle barrel shifter.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] op,
                                          input logic [4:0] amt);
        logic [31:0] r;
        if (op[2:1] == 2'b11) begin
            r = $signed(d) >>> amt;
        end else begin
            case (op[1:0])
                2'b00:   r = d << amt;
                2'b01:   r = d >> amt;
                2'b10:   r = (amt == 5'd0) ? d : ((d << amt) | (d >> (32 - amt)));
                default: r = (amt == 5'd0) ? d : ((d >> amt) | (d << (32 - amt)));
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for the accept edge, queue the expected result.
    task automatic send(input logic [31:0] d, input logic [2:0] op, input logic [4:0] amt,
                        input bit hold);
        int unsigned guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_opsel  = op;
        in_amount = amt;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
        end
        tick();
        if (!hold) in_valid = 1'b0;
        exp_q.push_back(model(d, op, amt));
    endtask

    // Wait for the result, check latency/data, optionally stall, then handshake.
    task automatic collect(input string tag, input int amt, input int stall, input bit early);
        int cycles = 0;
        logic [31:0] exp;
        out_ready = early;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, amt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, exp_q.size(), 32'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check({tag, "_data"}, out_data, exp);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            tick();
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_data"}, out_data, exp);
            check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_post_data_held"}, out_data, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opsel  = '0;
        in_amount = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy_after", {31'd0, busy}, 32'd0);

        // Directed cases.
        send(32'h12345678, OP_SLL, 5'd0, 1'b0);
        collect("sll0", 0, 0, 1'b0);
        send(32'h80000000, OP_SRA, 5'd4, 1'b0);
        collect("sra110", 4, 0, 1'b0);
        send(32'h80000000, OP_SRA2, 5'd4, 1'b0);
        collect("sra111", 4, 0, 1'b0);
        send(32'h80000000, OP_SRL, 5'd4, 1'b0);
        collect("srl4", 4, 0, 1'b0);
        send(32'h80000001, OP_ROL, 5'd1, 1'b0);
        collect("rol1", 1, 0, 1'b0);
        send(32'h00000001, OP_ROR, 5'd4, 1'b0);
        collect("ror4", 4, 0, 1'b0);
        send(32'h00000001, OP_ROL, 5'd31, 1'b0);
        collect("rol31", 31, 0, 1'b0);
        send(32'h00000001, 3'b100, 5'd7, 1'b0);
        collect("sll100", 7, 0, 1'b0);
        send(32'hF0000000, 3'b101, 5'd31, 1'b0);
        collect("srl101", 31, 0, 1'b0);

        // Backpressure: result held for 5 cycles.
        send(32'h00000001, OP_SLL, 5'd3, 1'b0);
        collect("bp", 3, 5, 1'b0);

        // out_ready asserted throughout the shift has no early effect.
        send(32'hA5A5_0F0F, OP_ROR, 5'd9, 1'b0);
        collect("early_rdy", 9, 0, 1'b1);

        // Request held during SHIFT with other operands must not be captured.
        send(32'h00000001, OP_SLL, 5'd3, 1'b1);
        in_data   = 32'hDEADBEEF;
        in_opsel  = OP_ROR;
        in_amount = 5'd5;
        collect("ign_first", 3, 0, 1'b0);
        send(32'hDEADBEEF, OP_ROR, 5'd5, 1'b0);
        collect("ign_second", 5, 0, 1'b0);

        // Reset in the middle of a shift discards the result.
        send(32'hF0000000, OP_SRL, 5'd20, 1'b0);
        exp_q.delete();
        repeat (7) tick();
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        end
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_zero", out_data, 32'd0);

        // Randomised operations, amounts, stalls and ready timing.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] d;
            logic [2:0]  op;
            logic [4:0]  amt;
            d   = $urandom;
            op  = 3'($urandom_range(0, 7));
            amt = 5'($urandom_range(0, 31));
            send(d, op, amt, 1'b0);
            collect("rand", int'(amt), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
